// File: rtl/tage_update_scheduler_if.sv
// tage_update_scheduler_if: commit, lookup-arbitration and table-port signals of the TAGE update scheduler
interface tage_update_scheduler_if #(
    parameter int DEPTH  = 4,
    parameter int INFO_W = 16
);
    logic                     pause;
    logic                     pred_req;
    logic                     pred_grant;
    logic                     commit_valid;
    logic                     commit_ready;
    logic [31:0]              committed_pc;
    logic [INFO_W-1:0]        committed_pred_info;
    logic                     committed_branch_taken;
    logic                     committed_mispred;
    logic                     upd_rd;
    logic                     upd_wr;
    logic [31:0]              upd_pc;
    logic [INFO_W-1:0]        upd_info;
    logic                     upd_taken;
    logic                     upd_mispred;
    logic                     flush_ubits_hi;
    logic                     flush_ubits_lo;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport slave (
        input  pause, pred_req, commit_valid, committed_pc, committed_pred_info,
               committed_branch_taken, committed_mispred,
        output pred_grant, commit_ready, upd_rd, upd_wr, upd_pc, upd_info, upd_taken,
               upd_mispred, flush_ubits_hi, flush_ubits_lo, fifo_count
    );

    modport master (
        output pause, pred_req, commit_valid, committed_pc, committed_pred_info,
               committed_branch_taken, committed_mispred,
        input  pred_grant, commit_ready, upd_rd, upd_wr, upd_pc, upd_info, upd_taken,
               upd_mispred, flush_ubits_hi, flush_ubits_lo, fifo_count
    );
endinterface

// File: rtl/tage_update_scheduler.sv
// tage_update_scheduler: shares the TAGE table port between lookups, buffered RMW updates and aging flushes (aging enabled by TAGE_UBIT_AGING_EN)
module tage_update_scheduler #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    parameter int AGE_PERIOD = 1024,
    parameter int INFO_W     = 16
) (
    input logic clk,
    input logic rst,
    tage_update_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, AGE} state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INFO_W-1:0] info;
        logic              taken;
        logic              mispred;
    } entry_t;

    state_t        state, state_nx;
    entry_t        mem [DEPTH];
    entry_t        upd;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve;
    logic          push, pop, forced, slot_free, nonempty, age_pending, grant;

    assign nonempty         = count != '0;
    assign slot_free        = ~bus.pred_req | bus.pause;
    assign forced           = count == (AW+1)'(DEPTH) || starve == SW'(STARVE_MAX);
    assign bus.commit_ready = count != (AW+1)'(DEPTH);
    assign push             = bus.commit_valid & bus.commit_ready;
    assign bus.pred_grant   = grant;
    assign bus.upd_rd       = state == RD;
    assign bus.upd_wr       = state == WR;
    assign bus.upd_pc       = upd.pc;
    assign bus.upd_info     = upd.info;
    assign bus.upd_taken    = upd.taken;
    assign bus.upd_mispred  = upd.mispred;
    assign bus.fifo_count   = count;

    // port arbitration: lookups win in IDLE unless an update is forced
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                grant = bus.pred_req & ~bus.pause & ~forced;
                if (nonempty && (slot_free || forced)) begin
                    state_nx = RD;
                    pop      = 1'b1;
                end else if (age_pending && !nonempty && slot_free) begin
                    state_nx = AGE;
                end
            end
            RD:      state_nx = WR;
            default: state_nx = IDLE;
        endcase
    end

    // update FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{bus.committed_pc, bus.committed_pred_info,
                                 bus.committed_branch_taken, bus.committed_mispred};
    end

    // FSM, FIFO pointers, in-flight update latch and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            starve <= '0;
            upd    <= '0;
        end else begin
            state <= state_nx;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                upd  <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            starve <= pop ? '0 :
                      (nonempty && grant && starve != SW'(STARVE_MAX)) ? starve + 1'b1 : starve;
        end
    end

`ifdef TAGE_UBIT_AGING_EN
    localparam int GW = $clog2(AGE_PERIOD);

    logic [GW-1:0] age_cnt;
    logic          age_sel;

    assign bus.flush_ubits_hi = state == AGE && !age_sel;
    assign bus.flush_ubits_lo = state == AGE && age_sel;

    // commit counter raises a single merged aging request; flushes alternate hi/lo
    always_ff @(posedge clk) begin
        if (rst) begin
            age_cnt     <= '0;
            age_pending <= 1'b0;
            age_sel     <= 1'b0;
        end else begin
            if (push) age_cnt <= age_cnt + 1'b1;
            age_pending <= (push && age_cnt == GW'(AGE_PERIOD - 1)) ||
                           (age_pending && !(state == IDLE && state_nx == AGE));
            if (state == AGE) age_sel <= ~age_sel;
        end
    end
`else
    assign age_pending        = 1'b0;
    assign bus.flush_ubits_hi = 1'b0;
    assign bus.flush_ubits_lo = 1'b0;
`endif
endmodule

// File: tb/tb_tage_update_scheduler.sv
// tb_tage_update_scheduler: directed and random stimulus checked against a queue-based reference model
module tb_tage_update_scheduler;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int AGE_PERIOD = 4;
    localparam int INFO_W     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tage_update_scheduler_if #(.DEPTH(DEPTH), .INFO_W(INFO_W)) bus ();

    tage_update_scheduler #(
        .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .AGE_PERIOD(AGE_PERIOD), .INFO_W(INFO_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0]       pc;
        logic [INFO_W-1:0] info;
        logic              taken;
        logic              mispred;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    int   checks = 0;
    int   errors = 0;
    int   rmw;
    int   starve;
    int   commits;
    bit   aging;
    bit   age_pend;
    bit   next_hi;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rmw      = 0;
        starve   = 0;
        commits  = 0;
        aging    = 0;
        age_pend = 0;
        next_hi  = 1;
    endtask

    task automatic step(input bit r, input bit p, input bit req, input bit cv,
                        input logic [31:0] pc, input logic [INFO_W-1:0] info,
                        input bit tk, input bit mp);
        ent_t e;
        bit   idle, force_u, want, grant, ready, start_upd, start_age, acc, hi, lo;
        int   users;
        @(negedge clk);
        rst                        = r;
        bus.pause                  = p;
        bus.pred_req               = req;
        bus.commit_valid           = cv;
        bus.committed_pc           = pc;
        bus.committed_pred_info    = info;
        bus.committed_branch_taken = tk;
        bus.committed_mispred      = mp;
        #1;
        idle      = rmw == 0 && !aging;
        force_u   = q.size() == DEPTH || starve >= STARVE_MAX;
        want      = req && !p;
        grant     = idle && want && !force_u;
        ready     = q.size() < DEPTH;
        start_upd = idle && q.size() > 0 && (!want || force_u);
        start_age = idle && !start_upd && age_pend && q.size() == 0 && !want;
        hi        = aging && next_hi;
        lo        = aging && !next_hi;
        check("pred_grant", bus.pred_grant, grant);
        check("upd_rd", bus.upd_rd, rmw == 1);
        check("upd_wr", bus.upd_wr, rmw == 2);
        check("commit_ready", bus.commit_ready, ready);
        check("fifo_count", bus.fifo_count, q.size());
        check("flush_hi", bus.flush_ubits_hi, hi);
        check("flush_lo", bus.flush_ubits_lo, lo);
        users = int'(bus.pred_grant) + int'(bus.upd_rd) + int'(bus.upd_wr) +
                int'(bus.flush_ubits_hi) + int'(bus.flush_ubits_lo);
        check("port_excl", users > 1, 0);
        if (rmw != 0)
            check("upd_payload", {bus.upd_pc, bus.upd_info, bus.upd_taken, bus.upd_mispred},
                  {cur.pc, cur.info, cur.taken, cur.mispred});
        @(posedge clk);
        if (r) begin
            model_reset();
            return;
        end
        acc = cv && ready;
        if (start_upd) begin
            cur    = q.pop_front();
            starve = 0;
        end else if (idle && q.size() > 0 && grant && starve < STARVE_MAX) begin
            starve++;
        end
        if (acc) begin
            e.pc      = pc;
            e.info    = info;
            e.taken   = tk;
            e.mispred = mp;
            q.push_back(e);
        end
        rmw = start_upd ? 1 : (rmw == 1 ? 2 : 0);
        if (aging) next_hi = !next_hi;
        aging = start_age;
`ifdef TAGE_UBIT_AGING_EN
        if (acc) commits++;
        age_pend = (acc && commits % AGE_PERIOD == 0) || (age_pend && !start_age);
`endif
    endtask

    task automatic idle_steps(input bit req, input int n);
        for (int i = 0; i < n; i++) step(0, 0, req, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.pause                  = 0;
        bus.pred_req               = 0;
        bus.commit_valid           = 0;
        bus.committed_pc           = 0;
        bus.committed_pred_info    = 0;
        bus.committed_branch_taken = 0;
        bus.committed_mispred      = 0;
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        check("rst_commit_ready", bus.commit_ready, 1);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_upd_rd", bus.upd_rd, 0);

        step(0, 0, 0, 1, 32'h1000, 16'h00a5, 1, 0);
        idle_steps(0, 4);

        step(0, 0, 1, 1, 32'h2000, 16'h1234, 0, 1);
        idle_steps(1, 14);

        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'h3000 + 4 * i, 16'(i), i[0], i[1]);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 32'h3100 + 4 * i, 16'(i + 8), 0, 0);
        idle_steps(1, 30);

        step(0, 0, 0, 1, 32'h4000, 16'h4444, 1, 1);
        for (int i = 0; i < 5 && rmw != 1; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        check("reached_rd", rmw, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle_steps(0, 3);

        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 32'h5000 + 4 * i, 16'(i), 0, 0);
            idle_steps(0, 3);
        end
        idle_steps(0, 6);

        for (int i = 0; i < 4000; i++) begin
            int req_pct;
            req_pct = (i / 500) % 2 == 0 ? 85 : 30;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) < req_pct,
                 $urandom_range(0, 99) < 45,
                 $urandom, 16'($urandom), 1'($urandom), 1'($urandom));
        end
        idle_steps(0, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
